pet_screen_ctrl: RTL and testbench

PET_SCREEN_CTRL -- requirements
Module: pet_screen_ctrl

---
 rtl/pet_screen_ctrl_if.sv | 33 +++
 rtl/pet_screen_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pet_screen_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pet_screen_ctrl_if.sv
// Bundle of pet-sense inputs, button pulses, renderer pixels and the
// controller's page/expression/pixel outputs.
// master: the environment driving the controller; slave: the controller.
interface pet_screen_ctrl_if;
  logic        awaking;
  logic        touched;
  logic        expecting;
  logic        petting;
  logic        pressed;
  logic        left;
  logic        right;
  logic [79:0] expr_pix;
  logic [15:0] menu_pix;
  logic [15:0] app_pix;
  logic [1:0]  page;
  logic [2:0]  express;
  logic [2:0]  menu_idx;
  logic [2:0]  app_id;
  logic [15:0] pix;
  logic        tick;

  modport master (
    output awaking, touched, expecting, petting, pressed, left, right,
    output expr_pix, menu_pix, app_pix,
    input  page, express, menu_idx, app_id, pix, tick
  );

  modport slave (
    input  awaking, touched, expecting, petting, pressed, left, right,
    input  expr_pix, menu_pix, app_pix,
    output page, express, menu_idx, app_id, pix, tick
  );
endinterface

// File: rtl/pet_screen_ctrl.sv
// Pet screen controller: expression FSM, menu/app page navigation, tick
// prescaler and a registered pixel mux toward the LCD driver.
// Optional feature macro PET_MENU_TIMEOUT_EN: when defined, the menu page
// falls back to the expression page after MENU_TICKS quiet ticks.
module pet_screen_ctrl #(
  parameter int N_MENU      = 3,
  parameter int TICK_CYCLES = 100_000_000,
  parameter int IDLE_TICKS  = 10,
  parameter int MENU_TICKS  = 10
) (
  input logic              clk,
  input logic              rst,
  pet_screen_ctrl_if.slave bus
);

  typedef enum logic [1:0] {PG_EXPR = 2'd0, PG_MENU = 2'd1, PG_APP = 2'd2} page_t;
  typedef enum logic [2:0] {
    EX_IDLE = 3'd0, EX_HAPPY = 3'd1, EX_SATISFY = 3'd2, EX_SLEEP = 3'd3, EX_EXPECT = 3'd4
  } express_t;

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int IW = $clog2(IDLE_TICKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_MAX   = IW'(IDLE_TICKS);
  localparam logic [2:0]    MENU_LAST  = 3'(N_MENU - 1);

  logic [PW-1:0] presc_reg;
  page_t         page_reg;
  express_t      express_reg;
  logic [2:0]    menu_idx_reg;
  logic [2:0]    app_id_reg;
  logic [15:0]   pix_reg;
  logic [IW-1:0] idle_cnt_reg;
  logic [IW-1:0] idle_next;
  logic [15:0]   pix_next;
  logic          tick;
  logic          any_in;
  logic          sleep_go;
  logic          menu_to;

  assign tick   = (presc_reg == PRESC_LAST);
  assign any_in = bus.awaking | bus.touched | bus.expecting | bus.petting |
                  bus.pressed | bus.left | bus.right;

  // Free-running prescaler producing the timing tick
  always_ff @(posedge clk) begin
    if (rst || tick) presc_reg <= '0;
    else             presc_reg <= presc_reg + 1'b1;
  end

  // Quiet-time counter: only runs while the pet is idle on the expression page
  always_comb begin
    idle_next = idle_cnt_reg;
    if (page_reg != PG_EXPR || express_reg != EX_IDLE || any_in)
      idle_next = '0;
    else if (tick && idle_cnt_reg != IDLE_MAX)
      idle_next = idle_cnt_reg + 1'b1;
  end
  assign sleep_go = (idle_next == IDLE_MAX);

`ifdef PET_MENU_TIMEOUT_EN
  localparam int MW = $clog2(MENU_TICKS + 1);
  localparam logic [MW-1:0] MENU_MAX = MW'(MENU_TICKS);
  logic [MW-1:0] menu_cnt_reg;
  logic [MW-1:0] menu_cnt_next;

  // Menu inactivity counter; any button restarts it
  always_comb begin
    menu_cnt_next = menu_cnt_reg;
    if (page_reg != PG_MENU || bus.pressed || bus.left || bus.right)
      menu_cnt_next = '0;
    else if (tick && menu_cnt_reg != MENU_MAX)
      menu_cnt_next = menu_cnt_reg + 1'b1;
  end
  assign menu_to = (page_reg == PG_MENU) && (menu_cnt_next == MENU_MAX);

  // Menu counter register, cleared once the timeout fires
  always_ff @(posedge clk) begin
    if (rst || menu_to) menu_cnt_reg <= '0;
    else                menu_cnt_reg <= menu_cnt_next;
  end
`else
  logic unused_menu_cfg;
  assign unused_menu_cfg = (MENU_TICKS == 0);
  assign menu_to = 1'b0;
`endif

  // Pixel source selection from the current page/expression
  always_comb begin
    pix_next = 16'h0000;
    case (page_reg)
      PG_EXPR: begin
        case (express_reg)
          EX_IDLE:    pix_next = bus.expr_pix[15:0];
          EX_HAPPY:   pix_next = bus.expr_pix[31:16];
          EX_SATISFY: pix_next = bus.expr_pix[47:32];
          EX_SLEEP:   pix_next = bus.expr_pix[63:48];
          EX_EXPECT:  pix_next = bus.expr_pix[79:64];
          default:    pix_next = 16'h0000;
        endcase
      end
      PG_MENU: pix_next = bus.menu_pix;
      PG_APP:  pix_next = bus.app_pix;
      default: pix_next = 16'h0000;
    endcase
  end

  // Page and expression state machine with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      page_reg     <= PG_EXPR;
      express_reg  <= EX_IDLE;
      menu_idx_reg <= 3'd0;
      app_id_reg   <= 3'd0;
      pix_reg      <= 16'h0000;
      idle_cnt_reg <= '0;
    end else begin
      pix_reg      <= pix_next;
      idle_cnt_reg <= sleep_go ? '0 : idle_next;
      case (page_reg)
        PG_EXPR: begin
          if (bus.pressed) page_reg <= PG_MENU;
          case (express_reg)
            EX_IDLE: begin
              if (sleep_go)           express_reg <= EX_SLEEP;
              else if (bus.expecting) express_reg <= EX_EXPECT;
              else if (bus.petting)   express_reg <= EX_SATISFY;
              else if (bus.touched)   express_reg <= EX_HAPPY;
            end
            EX_HAPPY: begin
              if (bus.petting)       express_reg <= EX_SATISFY;
              else if (!bus.touched) express_reg <= EX_IDLE;
            end
            EX_SATISFY: if (!bus.petting) express_reg <= EX_EXPECT;
            EX_EXPECT: begin
              if (bus.petting)         express_reg <= EX_SATISFY;
              else if (!bus.expecting) express_reg <= EX_IDLE;
            end
            // Leaving for the menu also wakes the pet
            EX_SLEEP: if (bus.awaking || bus.pressed) express_reg <= EX_IDLE;
            default:  express_reg <= EX_IDLE;
          endcase
        end
        PG_MENU: begin
          if (bus.pressed) begin
            page_reg   <= PG_APP;
            app_id_reg <= menu_idx_reg;
          end else if (menu_to) begin
            page_reg    <= PG_EXPR;
            express_reg <= EX_IDLE;
          end else if (bus.right && !bus.left) begin
            menu_idx_reg <= (menu_idx_reg == MENU_LAST) ? 3'd0 : menu_idx_reg + 3'd1;
          end else if (bus.left && !bus.right) begin
            menu_idx_reg <= (menu_idx_reg == 3'd0) ? MENU_LAST : menu_idx_reg - 3'd1;
          end
        end
        PG_APP:  if (bus.pressed) page_reg <= PG_MENU;
        default: begin
          page_reg    <= PG_EXPR;
          express_reg <= EX_IDLE;
        end
      endcase
      // Expression is frozen off the expression page, but never in a bad code
      if (page_reg != PG_EXPR && express_reg > EX_EXPECT) express_reg <= EX_IDLE;
    end
  end

  assign bus.page     = page_reg;
  assign bus.express  = express_reg;
  assign bus.menu_idx = menu_idx_reg;
  assign bus.app_id   = app_id_reg;
  assign bus.pix      = pix_reg;
  assign bus.tick     = tick;

endmodule

// File: tb/tb_pet_screen_ctrl.sv
// Directed bench for pet_screen_ctrl: a vector table for expression and
// menu navigation plus hand-written sequences for tick/sleep timing,
// menu timeout and reset.
module tb_pet_screen_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  pet_screen_ctrl_if bus ();

  pet_screen_ctrl #(
    .N_MENU(3), .TICK_CYCLES(4), .IDLE_TICKS(3), .MENU_TICKS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Input bit positions: {awaking, touched, expecting, petting, pressed, left, right}
  localparam logic [6:0] NO = 7'b0000000;
  localparam logic [6:0] AW = 7'b1000000;
  localparam logic [6:0] TO = 7'b0100000;
  localparam logic [6:0] EX = 7'b0010000;
  localparam logic [6:0] PE = 7'b0001000;
  localparam logic [6:0] PR = 7'b0000100;
  localparam logic [6:0] LE = 7'b0000010;
  localparam logic [6:0] RI = 7'b0000001;

  typedef struct {
    logic [6:0]  in;
    logic        rst_in;
    logic [15:0] app;
    logic [1:0]  page;
    logic [2:0]  expr;
    logic [2:0]  menu;
    logic [2:0]  app_id;
    logic        chk_pix;
    logic [15:0] pix;
  } vec_t;

  vec_t vecs [33];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] v);
    {bus.awaking, bus.touched, bus.expecting, bus.petting,
     bus.pressed, bus.left, bus.right} = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".page"},     16'(bus.page),     16'd0);
    chk({tag, ".express"},  16'(bus.express),  16'd0);
    chk({tag, ".menu_idx"}, 16'(bus.menu_idx), 16'd0);
    chk({tag, ".app_id"},   16'(bus.app_id),   16'd0);
    chk({tag, ".pix"},      bus.pix,           16'h0000);
    chk({tag, ".tick"},     16'(bus.tick),     16'd0);
  endtask

  // From a fresh reset with no input: tick after edges 3,7,11, SLEEP at edge 12
  task automatic idle_to_sleep(input string tag);
    drive(NO);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("%s.tick%0d", tag, k), 16'(bus.tick), (k % 4 == 3) ? 16'd1 : 16'd0);
      chk($sformatf("%s.expr%0d", tag, k), 16'(bus.express), (k == 12) ? 16'd3 : 16'd0);
    end
  endtask

  initial begin
    // in, rst, app_pix, page, express, menu_idx, app_id, chk_pix, pix
    vecs[0]  = '{TO|PE, 1'b0, 16'h1234, 2'd0, 3'd2, 3'd0, 3'd0, 1'b1, 16'hE000};
    vecs[1]  = '{NO,    1'b0, 16'h1234, 2'd0, 3'd4, 3'd0, 3'd0, 1'b1, 16'hE002};
    vecs[2]  = '{NO,    1'b0, 16'h1234, 2'd0, 3'd0, 3'd0, 3'd0, 1'b1, 16'hE004};
    vecs[3]  = '{TO,    1'b0, 16'h1234, 2'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'hE000};
    vecs[4]  = '{TO|PE, 1'b0, 16'h1234, 2'd0, 3'd2, 3'd0, 3'd0, 1'b1, 16'hE001};
    vecs[5]  = '{EX,    1'b0, 16'h1234, 2'd0, 3'd4, 3'd0, 3'd0, 1'b0, 16'h0000};
    vecs[6]  = '{PE,    1'b0, 16'h1234, 2'd0, 3'd2, 3'd0, 3'd0, 1'b0, 16'h0000};
    vecs[7]  = '{EX,    1'b0, 16'h1234, 2'd0, 3'd4, 3'd0, 3'd0, 1'b0, 16'h0000};
    vecs[8]  = '{EX,    1'b0, 16'h1234, 2'd0, 3'd4, 3'd0, 3'd0, 1'b0, 16'h0000};
    vecs[9]  = '{NO,    1'b0, 16'h1234, 2'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000};
    vecs[10] = '{TO|EX, 1'b0, 16'h1234, 2'd0, 3'd4, 3'd0, 3'd0, 1'b0, 16'h0000};
    vecs[11] = '{TO,    1'b0, 16'h1234, 2'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000};
    vecs[12] = '{TO,    1'b0, 16'h1234, 2'd0, 3'd1, 3'd0, 3'd0, 1'b0, 16'h0000};
    vecs[13] = '{TO|EX, 1'b0, 16'h1234, 2'd0, 3'd1, 3'd0, 3'd0, 1'b0, 16'h0000};
    vecs[14] = '{NO,    1'b0, 16'h1234, 2'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000};
    vecs[15] = '{AW,    1'b0, 16'h1234, 2'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000};
    vecs[16] = '{PR,    1'b0, 16'h1234, 2'd1, 3'd0, 3'd0, 3'd0, 1'b1, 16'hE000};
    vecs[17] = '{TO,    1'b0, 16'h1234, 2'd1, 3'd0, 3'd0, 3'd0, 1'b1, 16'h5A5A};
    vecs[18] = '{RI,    1'b0, 16'h1234, 2'd1, 3'd0, 3'd1, 3'd0, 1'b0, 16'h0000};
    vecs[19] = '{RI,    1'b0, 16'h1234, 2'd1, 3'd0, 3'd2, 3'd0, 1'b0, 16'h0000};
    vecs[20] = '{RI,    1'b0, 16'h1234, 2'd1, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000};
    vecs[21] = '{LE,    1'b0, 16'h1234, 2'd1, 3'd0, 3'd2, 3'd0, 1'b0, 16'h0000};
    vecs[22] = '{LE|RI, 1'b0, 16'h1234, 2'd1, 3'd0, 3'd2, 3'd0, 1'b0, 16'h0000};
    vecs[23] = '{PR,    1'b0, 16'h1234, 2'd2, 3'd0, 3'd2, 3'd2, 1'b1, 16'h5A5A};
    vecs[24] = '{NO,    1'b0, 16'hABCD, 2'd2, 3'd0, 3'd2, 3'd2, 1'b1, 16'hABCD};
    vecs[25] = '{RI,    1'b0, 16'hABCD, 2'd2, 3'd0, 3'd2, 3'd2, 1'b1, 16'hABCD};
    vecs[26] = '{PR,    1'b0, 16'hABCD, 2'd1, 3'd0, 3'd2, 3'd2, 1'b0, 16'h0000};
    vecs[27] = '{PR|LE, 1'b0, 16'hABCD, 2'd2, 3'd0, 3'd2, 3'd2, 1'b0, 16'h0000};
    vecs[28] = '{PR,    1'b0, 16'hABCD, 2'd1, 3'd0, 3'd2, 3'd2, 1'b0, 16'h0000};
    vecs[29] = '{LE,    1'b0, 16'hABCD, 2'd1, 3'd0, 3'd1, 3'd2, 1'b0, 16'h0000};
    vecs[30] = '{PR|RI, 1'b0, 16'hABCD, 2'd2, 3'd0, 3'd1, 3'd1, 1'b0, 16'h0000};
    vecs[31] = '{PR,    1'b0, 16'hABCD, 2'd1, 3'd0, 3'd1, 3'd1, 1'b0, 16'h0000};
    vecs[32] = '{RI,    1'b1, 16'hABCD, 2'd0, 3'd0, 3'd0, 3'd0, 1'b1, 16'h0000};

    bus.expr_pix = {16'hE004, 16'hE003, 16'hE002, 16'hE001, 16'hE000};
    bus.menu_pix = 16'h5A5A;
    bus.app_pix  = 16'h1234;
    drive(NO);

    // Power-on reset
    rst = 1'b1;
    step();
    check_reset("rst0");
    rst = 1'b0;

    // Tick cadence and sleep after three quiet ticks
    idle_to_sleep("sleep0");
    step();
    chk("sleep0.hold", 16'(bus.express), 16'd3);
    chk("sleep0.pix",  bus.pix,          16'hE003);
    drive(AW);
    step();
    chk("wake.express", 16'(bus.express), 16'd0);
    chk("wake.pix",     bus.pix,          16'hE003);

    // Table-driven expression and menu vectors
    for (int i = 0; i < 33; i++) begin
      drive(vecs[i].in);
      rst         = vecs[i].rst_in;
      bus.app_pix = vecs[i].app;
      step();
      chk($sformatf("v%0d.page", i),     16'(bus.page),     16'(vecs[i].page));
      chk($sformatf("v%0d.express", i),  16'(bus.express),  16'(vecs[i].expr));
      chk($sformatf("v%0d.menu_idx", i), 16'(bus.menu_idx), 16'(vecs[i].menu));
      chk($sformatf("v%0d.app_id", i),   16'(bus.app_id),   16'(vecs[i].app_id));
      if (vecs[i].chk_pix)
        chk($sformatf("v%0d.pix", i), bus.pix, vecs[i].pix);
      rst = 1'b0;
    end
    chk("v32.tick", 16'(bus.tick), 16'd0);

    // Menu inactivity: timeout build returns to the expression page
    drive(PR);
    step();
    chk("mto.enter", 16'(bus.page), 16'd1);
    drive(NO);
    for (int k = 0; k < 8; k++) step();
`ifdef PET_MENU_TIMEOUT_EN
    chk("mto.page", 16'(bus.page), 16'd0);
`else
    chk("mto.page", 16'(bus.page), 16'd1);
`endif
    chk("mto.express", 16'(bus.express), 16'd0);

    // Reset while a button is pulsing
    drive(RI);
    rst = 1'b1;
    step();
    check_reset("rst1");
    rst = 1'b0;

    // Sense inputs ignored in SLEEP; pressing wakes the pet into the menu
    idle_to_sleep("sleep1");
    drive(TO | PE | EX);
    step();
    chk("sleep1.ignore", 16'(bus.express), 16'd3);
    drive(PR);
    step();
    chk("sleep1.page",    16'(bus.page),    16'd1);
    chk("sleep1.express", 16'(bus.express), 16'd0);
    drive(NO);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
